// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - register map, CTRL fields, modes and FSM encoding for timer_counter
package timer_counter_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - peripheral-bus word access and interrupt line between bridge and timer
interface timer_counter_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counter with one-shot / auto-reload interrupt
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int CTRL_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  state_t            state, stateNext;
  logic [CTRL_W-1:0] ctrl, ctrlNext;
  logic [CNT_W-1:0]  preset, presetNext;
  logic [CNT_W-1:0]  count, countNext;
  logic              irqPending, irqPendingNext;
  logic              irqReg;
  logic              ctrlWrite, presetWrite;
  logic [1:0]        mode;

  assign ctrlWrite   = bus.WE && (bus.Addr == ADDR_CTRL);
  assign presetWrite = bus.WE && (bus.Addr == ADDR_PRESET);
  assign mode        = ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ctrl       <= '0;
      preset     <= '0;
      count      <= '0;
      irqPending <= 1'b0;
      irqReg     <= 1'b0;
    end else begin
      state      <= stateNext;
      ctrl       <= ctrlNext;
      preset     <= presetNext;
      count      <= countNext;
      irqPending <= irqPendingNext;
      irqReg     <= irqPendingNext & ctrlNext[CTRL_IM];
    end
  end

  always_comb begin
    stateNext      = state;
    ctrlNext       = ctrl;
    presetNext     = preset;
    countNext      = count;
    irqPendingNext = irqPending;

    // A register write acknowledges the interrupt, but a fresh expiry on the same edge still wins.
    if (ctrlWrite || presetWrite) begin
      irqPendingNext = 1'b0;
    end

    case (state)
      IDLE: begin
        if (ctrl[CTRL_EN]) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        countNext = preset;
        stateNext = CNT;
      end
      CNT: begin
        if (!ctrl[CTRL_EN]) begin
          stateNext = IDLE;
        end else if (count > CNT_W'(1)) begin
          countNext = count - CNT_W'(1);
        end else begin
          // Zero preset lands here too, so the count never wraps.
          countNext      = '0;
          irqPendingNext = 1'b1;
          stateNext      = INT;
        end
      end
      INT: begin
        if (mode == MODE_RELOAD) begin
          irqPendingNext = 1'b0;
          stateNext      = LOAD;
        end else begin
          ctrlNext[CTRL_EN] = 1'b0;
          stateNext         = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (presetWrite) begin
      presetNext = bus.Din[CNT_W-1:0];
    end
    if (ctrlWrite) begin
      ctrlNext = bus.Din[CTRL_W-1:0];
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (bus.Addr)
      ADDR_CTRL:   bus.Dout = 32'(ctrl);
      ADDR_PRESET: bus.Dout = 32'(preset);
      ADDR_COUNT:  bus.Dout = 32'(count);
      default:     bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = irqReg;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - randomized and directed checks of timer_counter against a timeline model
module tb_timer_counter;

  logic clk;
  logic reset;
  timer_counter_if bus();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total;
  int bad;
  bit checkOn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a run is described by the edge its load happens on and the edge it expires on.
  int unsigned edgeN, tLoad, tExp, elapsed;
  bit          busy, mPending, mIrq, mEn, wCtrl, wPre;
  logic [3:0]  mCtrl, newCtrl;
  logic [31:0] mPreset, mCount, loadVal;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edgeN = 0; busy = 0; tLoad = 0; tExp = 0; loadVal = 0;
      mCtrl = 0; mPreset = 0; mCount = 0; mPending = 0; mIrq = 0;
    end else begin
      edgeN++;
      mEn     = mCtrl[0];
      newCtrl = mCtrl;
      wCtrl   = bus.WE && (bus.Addr == 2'd0);
      wPre    = bus.WE && (bus.Addr == 2'd1);
      if (wCtrl || wPre) mPending = 0;
      if (!busy) begin
        if (mEn) begin
          busy  = 1;
          tLoad = edgeN + 1;
        end
      end else if (edgeN == tLoad) begin
        loadVal = mPreset;
        mCount  = mPreset;
        tExp    = edgeN + ((mPreset == 0) ? 1 : mPreset);
      end else if (edgeN <= tExp) begin
        if (!mEn) begin
          busy = 0;
        end else begin
          elapsed = edgeN - tLoad;
          mCount  = (loadVal > elapsed) ? loadVal - elapsed : 32'd0;
          if (edgeN == tExp) mPending = 1;
        end
      end else begin
        if (mCtrl[2:1] == 2'b01) begin
          mPending = 0;
          tLoad    = edgeN + 1;
        end else begin
          newCtrl[0] = 1'b0;
          busy       = 0;
        end
      end
      if (wPre)  mPreset = bus.Din;
      if (wCtrl) newCtrl = bus.Din[3:0];
      mCtrl = newCtrl;
      mIrq  = mPending & mCtrl[3];
    end
  end

  function automatic logic [31:0] modelDout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, mCtrl};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (checkOn) begin
      check("model_dout", bus.Dout, modelDout(bus.Addr));
      check("model_irq", {31'd0, bus.IRQ}, {31'd0, mIrq});
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
    bus.Din  = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    check(name, bus.Dout, exp);
  endtask

  task automatic resetDut();
    bus.WE = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; checkOn = 0;
    reset = 1'b0;
    bus.Addr = 2'd0; bus.WE = 1'b0; bus.Din = 32'd0;
    #1 checkOn = 1;
    resetDut();

    rd(2'd0, "reset_ctrl", 32'd0);
    rd(2'd1, "reset_preset", 32'd0);
    rd(2'd2, "reset_count", 32'd0);
    check("reset_irq", {31'd0, bus.IRQ}, 32'd0);

    // Reset asserted mid-count aborts the run without an interrupt.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    repeat (3) step();
    #1 reset = 1'b0;
    rd(2'd0, "midreset_ctrl", 32'd0);
    rd(2'd1, "midreset_preset", 32'd0);
    rd(2'd2, "midreset_count", 32'd0);
    check("midreset_irq", {31'd0, bus.IRQ}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("postreset_irq", {31'd0, bus.IRQ}, 32'd0);
    end

    // One-shot, PRESET=3: COUNT 3,2,1,0 and IRQ five edges after the CTRL write.
    resetDut();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    bus.Addr = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k >= 2) check("oneshot_count", bus.Dout, 32'(5 - k));
      check("oneshot_irq", {31'd0, bus.IRQ}, (k == 5) ? 32'd1 : 32'd0);
    end
    step();
    rd(2'd0, "oneshot_ctrl_after", 32'h8);
    repeat (3) step();
    check("oneshot_irq_held", {31'd0, bus.IRQ}, 32'd1);
    wr(2'd0, 32'h0);
    check("oneshot_irq_cleared", {31'd0, bus.IRQ}, 32'd0);

    // Auto-reload, PRESET=2: one-cycle IRQ pulse every 4 cycles.
    resetDut();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    bus.Addr = 2'd2;
    for (int k = 1; k <= 13; k++) begin
      step();
      check("reload_irq", {31'd0, bus.IRQ}, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k == 6 || k == 10) check("reload_count", bus.Dout, 32'd2);
    end

    // Masked expiry: no IRQ, EN self-clears.
    resetDut();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("masked_irq", {31'd0, bus.IRQ}, 32'd0);
    end
    rd(2'd0, "masked_ctrl", 32'd0);

    // Stop mid-count with PRESET=10 freezes COUNT at 7.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    repeat (4) step();
    wr(2'd0, 32'h0);
    rd(2'd2, "stop_count", 32'd7);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stop_count_frozen", bus.Dout, 32'd7);
    end

    wr(2'd2, 32'hFFFF);
    rd(2'd2, "count_write_ignored", 32'd7);
    wr(2'd0, 32'hFFFF_FFF5);
    rd(2'd0, "ctrl_upper_bits", 32'h5);
    rd(2'd3, "addr3_reads_zero", 32'd0);

    // PRESET=0 expires at minimum latency without wrapping.
    resetDut();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    bus.Addr = 2'd2;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("zero_no_wrap", {31'd0, bus.Dout == 32'hFFFF_FFFF}, 32'd0);
      check("zero_irq", {31'd0, bus.IRQ}, (k >= 3) ? 32'd1 : 32'd0);
    end

    // PRESET rewrite mid-count affects only the next period.
    resetDut();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hB);
    repeat (3) step();
    wr(2'd1, 32'd9);
    bus.Addr = 2'd2;
    step();
    check("rewrite_count", bus.Dout, 32'd2);
    step();
    check("rewrite_irq_early", {31'd0, bus.IRQ}, 32'd0);
    step();
    check("rewrite_irq", {31'd0, bus.IRQ}, 32'd1);
    step();
    step();
    check("rewrite_reload", bus.Dout, 32'd9);

    // Randomized traffic, checked every cycle by the model.
    resetDut();
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [1:0] a;
      op = $urandom_range(0, 19);
      if (op == 0) begin
        resetDut();
      end else if (op < 9) begin
        a = 2'($urandom_range(0, 3));
        if (a == 2'd0)      wr(a, ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15)));
        else if (a == 2'd1) wr(a, 32'($urandom_range(0, 6)));
        else                wr(a, $urandom);
      end else begin
        bus.Addr = 2'($urandom_range(0, 3));
        repeat ($urandom_range(1, 6)) step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
